// File: rtl/ifdef_cond_filter_pkg.sv
// Shared types for the conditional-compilation filter:
// token opcodes, error codes, FSM states, stack entry.
package ifdef_pkg;

  typedef enum logic [2:0] {
    OP_BODY   = 3'd0,
    OP_IFDEF  = 3'd1,
    OP_IFNDEF = 3'd2,
    OP_ELSIF  = 3'd3,
    OP_ELSE   = 3'd4,
    OP_ENDIF  = 3'd5,
    OP_DEFINE = 3'd6,
    OP_UNDEF  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_ORPHAN   = 2'd2,
    ERR_UNTERM   = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ERROR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic active;
    logic taken;
    logic seen_else;
  } cond_t;

endpackage

// File: rtl/ifdef_cond_filter_if.sv
// Token stream bundle: upstream directive lexer side
// and downstream body-token consumer side.
interface ifdef_cond_filter_if #(
  parameter int MID_W     = 4,
  parameter int PAYLOAD_W = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [MID_W-1:0]     in_mid;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid,
    input  in_ready,
    output in_op,
    output in_mid,
    output in_payload,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_payload
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_op,
    input  in_mid,
    input  in_payload,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_payload
  );

endinterface

// File: rtl/ifdef_cond_filter_stack.sv
// Condition LIFO: one {active,taken,seen_else}
// entry per open `ifdef level.
module ifdef_cond_stack
  import ifdef_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          upd,
  input  cond_t         push_entry,
  input  cond_t         upd_entry,
  output cond_t         top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cond_t         mem [DEPTH];
  logic [DW-1:0] top_idx;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = depth - DW'(1);
  assign top     = empty ? '0 : mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[depth[AW-1:0]] <= push_entry;
      depth              <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end else if (upd && !empty) begin
      mem[top_idx[AW-1:0]] <= upd_entry;
    end
  end

endmodule

// File: rtl/ifdef_cond_filter.sv
// Streaming `ifdef filter: tracks macro state and nesting,
// forwards only BODY tokens that sit in active regions.
module ifdef_cond_filter
  import ifdef_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NMACRO    = 16,
  parameter int PAYLOAD_W = 8,
  parameter int MID_W     = $clog2(NMACRO),
  parameter int DW        = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  ifdef_cond_filter_if.slave  bus,
  output logic [DW-1:0]       depth,
  output logic [1:0]          err_code,
  output logic                done
);

  state_t               state;
  state_t               state_nx;
  err_t                 err_q;
  err_t                 err_nx;
  logic [NMACRO-1:0]    def_q;
  logic                 out_valid_q;
  logic [PAYLOAD_W-1:0] out_payload_q;

  logic          accept;
  logic          act;
  logic          dmid;
  logic          cval;
  op_t           op;
  logic          push;
  logic          pop;
  logic          upd;
  cond_t         push_e;
  cond_t         upd_e;
  cond_t         top;
  logic          full;
  logic          empty;
  logic          load;
  logic          def_we;
  logic          def_val;
  logic [DW-1:0] depth_after;

  ifdef_cond_stack #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .upd        (upd),
    .push_entry (push_e),
    .upd_entry  (upd_e),
    .top        (top),
    .depth      (depth),
    .full       (full),
    .empty      (empty)
  );

  assign bus.in_ready = (state != ST_RUN)
                      | ~out_valid_q
                      | bus.out_ready;

  assign accept = bus.in_valid & bus.in_ready;
  assign op     = op_t'(bus.in_op);
  assign act    = empty ? 1'b1 : top.active;
  assign dmid   = def_q[bus.in_mid];

  assign bus.out_valid   = out_valid_q;
  assign bus.out_payload = out_payload_q;
  assign err_code        = err_q;

  always_comb begin
    state_nx    = state;
    err_nx      = ERR_NONE;
    push        = 1'b0;
    pop         = 1'b0;
    upd         = 1'b0;
    push_e      = '0;
    upd_e       = '0;
    load        = 1'b0;
    def_we      = 1'b0;
    def_val     = 1'b0;
    cval        = 1'b0;
    depth_after = depth;
    unique case (1'b1)
      (accept && state == ST_RUN): begin
        unique case (op)
          OP_BODY: load = act;
          OP_IFDEF, OP_IFNDEF: begin
            cval   = (op == OP_IFNDEF) ? ~dmid : dmid;
            push_e = '{active:    act & cval,
                       taken:     ~act | cval,
                       seen_else: 1'b0};
            if (full) err_nx = ERR_OVERFLOW;
            else      push   = 1'b1;
          end
          OP_ELSIF: begin
            upd_e = '{active:    ~top.taken & dmid,
                      taken:     top.taken | dmid,
                      seen_else: top.seen_else};
            if (empty || top.seen_else) err_nx = ERR_ORPHAN;
            else                        upd    = 1'b1;
          end
          OP_ELSE: begin
            upd_e = '{active:    ~top.taken,
                      taken:     1'b1,
                      seen_else: 1'b1};
            if (empty || top.seen_else) err_nx = ERR_ORPHAN;
            else                        upd    = 1'b1;
          end
          OP_ENDIF: begin
            if (empty) err_nx = ERR_ORPHAN;
            else       pop    = 1'b1;
          end
          OP_DEFINE, OP_UNDEF: begin
            def_we  = act;
            def_val = (op == OP_DEFINE);
          end
          default: ;
        endcase
        if (push) depth_after = depth + DW'(1);
        if (pop)  depth_after = depth - DW'(1);
        // a stream that ends inside an open level is only
        // reported when the last token raised nothing else
        if (bus.in_last && err_nx == ERR_NONE &&
            depth_after != '0)
          err_nx = ERR_UNTERM;
        if (bus.in_last)            state_nx = ST_DONE;
        else if (err_nx != ERR_NONE) state_nx = ST_ERROR;
      end
      (accept && state == ST_ERROR): begin
        if (bus.in_last) state_nx = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= ERR_NONE;
      def_q <= '0;
      done  <= 1'b0;
    end else begin
      if (err_q == ERR_NONE && err_nx != ERR_NONE)
        err_q <= err_nx;
      if (def_we)
        def_q[bus.in_mid] <= def_val;
      done <= accept & bus.in_last & (state != ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
    end else if (load) begin
      out_valid_q   <= 1'b1;
      out_payload_q <= bus.in_payload;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifdef_cond_filter.sv
// Directed bench for ifdef_cond_filter with an output
// scoreboard of expected forwarded BODY payloads.
module tb_ifdef_cond_filter;
  import ifdef_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] depth;
  logic [1:0] err_code;
  logic       done;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  ifdef_cond_filter_if #(.MID_W(4), .PAYLOAD_W(8)) bus();

  ifdef_cond_filter #(
    .DEPTH     (8),
    .NMACRO    (16),
    .PAYLOAD_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .depth    (depth),
    .err_code (err_code),
    .done     (done)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 &&
        bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out observed=%0h expected=none",
               bus.out_payload);
      end else begin
        chk("out_payload", {24'h0, bus.out_payload},
            {24'h0, q.pop_front()});
      end
    end
  end

  task automatic drive(op_t op, logic [3:0] mid,
                       logic [7:0] pl, logic last, logic fwd);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_mid     = mid;
    bus.in_payload = pl;
    bus.in_last    = last;
    if (fwd) q.push_back(pl);
  endtask

  task automatic wait_accept(string tag);
    int n = 0;
    bit ok = 0;
    while (n < 50 && !ok) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL %s observed=timeout expected=accept", tag);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic tok(op_t op, logic [3:0] mid,
                     logic last = 1'b0);
    drive(op, mid, 8'h00, last, 1'b0);
    wait_accept("tok");
  endtask

  task automatic body(logic [7:0] pl, logic fwd,
                      logic last = 1'b0);
    drive(OP_BODY, 4'd0, pl, last, fwd);
    wait_accept("body");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_payload", {24'h0, bus.out_payload}, 32'h0);
    chk("rst_depth", {28'h0, depth}, 32'h0);
    chk("rst_err", {30'h0, err_code}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain(string tag);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_mid     = '0;
    bus.in_payload = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;

    // 1: basic if/else/elsif with nested define
    do_reset();
    tok(OP_IFDEF, 4'd1);
    body(8'hA0, 1'b0);
    tok(OP_ELSE, 4'd0);
    tok(OP_DEFINE, 4'd4);
    body(8'hB0, 1'b1);
    tok(OP_IFDEF, 4'd4);
    chk("t1_depth2", {28'h0, depth}, 32'd2);
    body(8'hC0, 1'b1);
    tok(OP_ELSIF, 4'd2);
    body(8'hD0, 1'b0);
    tok(OP_ENDIF, 4'd0);
    tok(OP_ENDIF, 4'd0);
    body(8'hE0, 1'b1, 1'b1);
    chk("t1_done", {31'h0, done}, 32'h1);
    chk("t1_err", {30'h0, err_code}, 32'h0);
    chk("t1_depth0", {28'h0, depth}, 32'h0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", {31'h0, done}, 32'h0);
    drain("t1_drain");

    // 2: ELSIF-taken chain, each level defines the next
    do_reset();
    tok(OP_DEFINE, 4'd4);
    for (int l = 0; l < 4; l++) begin
      tok(OP_IFDEF, 4'(5 + l));
      body(8'h20 + 8'(l), 1'b0);
      tok(OP_ELSIF, 4'(4 - l));
      body(8'h10 + 8'(l), 1'b1);
      chk("t2_depth", {28'h0, depth}, 32'(l + 1));
      if (l < 3) tok(OP_DEFINE, 4'(3 - l));
    end
    tok(OP_ELSE, 4'd0);
    body(8'h30, 1'b0);
    tok(OP_ENDIF, 4'd0);
    tok(OP_ENDIF, 4'd0);
    tok(OP_ENDIF, 4'd0);
    tok(OP_ENDIF, 4'd0, 1'b1);
    chk("t2_err", {30'h0, err_code}, 32'h0);
    chk("t2_done", {31'h0, done}, 32'h1);
    drain("t2_drain");

    // 3: overflow on the ninth push
    do_reset();
    tok(OP_DEFINE, 4'd1);
    for (int i = 0; i < 8; i++) tok(OP_IFDEF, 4'd1);
    chk("t3_depth8", {28'h0, depth}, 32'd8);
    chk("t3_err_pre", {30'h0, err_code}, 32'h0);
    tok(OP_IFDEF, 4'd1);
    chk("t3_err_ovf", {30'h0, err_code}, 32'h1);
    chk("t3_depth_hold", {28'h0, depth}, 32'd8);
    body(8'h77, 1'b0);
    tok(OP_ENDIF, 4'd0, 1'b1);
    chk("t3_err_keep", {30'h0, err_code}, 32'h1);
    chk("t3_done", {31'h0, done}, 32'h1);
    chk("t3_depth_end", {28'h0, depth}, 32'd8);
    drain("t3_drain");

    // 4: orphan directives and unterminated stream
    do_reset();
    tok(OP_ENDIF, 4'd0);
    chk("t4_endif0", {30'h0, err_code}, 32'h2);
    do_reset();
    tok(OP_IFDEF, 4'd0);
    tok(OP_ELSE, 4'd0);
    chk("t4_else1", {30'h0, err_code}, 32'h0);
    tok(OP_ELSE, 4'd0);
    chk("t4_else2", {30'h0, err_code}, 32'h2);
    chk("t4_else2_dep", {28'h0, depth}, 32'h1);
    do_reset();
    tok(OP_IFDEF, 4'd0);
    tok(OP_ELSE, 4'd0);
    tok(OP_ELSIF, 4'd0);
    chk("t4_elsif", {30'h0, err_code}, 32'h2);
    do_reset();
    tok(OP_IFDEF, 4'd0);
    body(8'h44, 1'b0, 1'b1);
    chk("t4_unterm", {30'h0, err_code}, 32'h3);
    chk("t4_unterm_done", {31'h0, done}, 32'h1);

    // 5: downstream backpressure
    do_reset();
    bus.out_ready = 1'b0;
    body(8'hA1, 1'b1);
    chk("t5_lat_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("t5_lat_pl", {24'h0, bus.out_payload}, 32'hA1);
    drive(OP_BODY, 4'd0, 8'hA2, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_rdy", {31'h0, bus.in_ready}, 32'h0);
      chk("t5_stall_pl", {24'h0, bus.out_payload}, 32'hA1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept("t5_a2");
    body(8'hA3, 1'b1);
    drain("t5_drain");

    // 6: inactive DEFINE, then a mid-stream reset
    do_reset();
    tok(OP_IFDEF, 4'd0);
    tok(OP_DEFINE, 4'd0);
    tok(OP_ENDIF, 4'd0);
    tok(OP_IFDEF, 4'd0);
    body(8'h58, 1'b0);
    tok(OP_ENDIF, 4'd0, 1'b1);
    chk("t6_err", {30'h0, err_code}, 32'h0);
    chk("t6_done", {31'h0, done}, 32'h1);
    drain("t6_drain");
    do_reset();
    bus.out_ready = 1'b0;
    tok(OP_DEFINE, 4'd3);
    tok(OP_IFDEF, 4'd3);
    body(8'h55, 1'b1);
    chk("t6_pre_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("t6_pre_depth", {28'h0, depth}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mid_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("t6_mid_pl", {24'h0, bus.out_payload}, 32'h0);
    chk("t6_mid_depth", {28'h0, depth}, 32'h0);
    q.delete();
    do_reset();
    body(8'h66, 1'b1);
    drain("t6_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
